// File: rtl/vga_mux_ctrl.sv
`default_nettype none
// ============================================================================
// vga_mux_ctrl : frame-synchronous VGA mux selection (manual / step / demo)
// Option: VGA_MUX_CTRL_SKIP_TEST_EN  Revision: 1.0
// ============================================================================
module vga_mux_ctrl #(
   parameter int DEBOUNCE_CYCLES = 650000,
   parameter int DEMO_FRAMES     = 120
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [3:0] sw_sel_in,
   input  logic       btn_next_in,
   input  logic       btn_mode_in,
   input  logic       new_frame_in,
   output logic [3:0] sel_out,
   output logic       demo_active_out,
   output logic       sel_changed_out
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int FC_W = (DEMO_FRAMES > 1) ? $clog2(DEMO_FRAMES) : 1;
   localparam logic [DB_W-1:0] c_DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [FC_W-1:0] c_FC_LAST = FC_W'(DEMO_FRAMES - 1);

   typedef enum logic [1:0] {
      S_MANUAL = 2'd0,
      S_STEP   = 2'd1,
      S_DEMO   = 2'd2
   } state_t;

   logic [3:0] r_sw_meta, r_sw_sync;
   logic [1:0] r_btn_meta, r_btn_sync;   // bit 0 = next, bit 1 = mode
   logic [1:0] w_btn_pulse;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_sw_meta  <= '0;
         r_sw_sync  <= '0;
         r_btn_meta <= '0;
         r_btn_sync <= '0;
      end else begin
         r_sw_meta  <= sw_sel_in;
         r_sw_sync  <= r_sw_meta;
         r_btn_meta <= {btn_mode_in, btn_next_in};
         r_btn_sync <= r_btn_meta;
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_db
      logic [DB_W-1:0] r_cnt;
      logic            r_acc, r_acc_d, r_pulse;

      always_ff @(posedge clk_in) begin
         if (rst_in) begin
            r_cnt   <= '0;
            r_acc   <= 1'b0;
            r_acc_d <= 1'b0;
            r_pulse <= 1'b0;
         end else begin
            r_acc_d <= r_acc;
            r_pulse <= r_acc & ~r_acc_d;
            if (r_btn_sync[gi] == r_acc) begin
               r_cnt <= '0;
            end else if (r_cnt == c_DB_LAST) begin
               r_cnt <= '0;
               r_acc <= ~r_acc;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end

      assign w_btn_pulse[gi] = r_pulse;
   end

   function automatic logic [3:0] f_nxt(input logic [3:0] x);
`ifdef VGA_MUX_CTRL_SKIP_TEST_EN
      f_nxt = (x >= 4'd11) ? 4'd0 : x + 4'd1;
`else
      f_nxt = x + 4'd1;
`endif
   endfunction

   state_t          r_state, w_state_nx;
   logic [3:0]      r_sel, r_pend, w_sel_nx, w_pend_nx;
   logic [FC_W-1:0] r_fcnt, w_fcnt_nx;
   logic            r_demo, r_chg;
   logic            w_next_p, w_mode_p;

   assign w_next_p = w_btn_pulse[0];
   assign w_mode_p = w_btn_pulse[1];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= S_MANUAL;
         r_sel   <= '0;
         r_pend  <= '0;
         r_fcnt  <= '0;
         r_demo  <= 1'b0;
         r_chg   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_sel   <= w_sel_nx;
         r_pend  <= w_pend_nx;
         r_fcnt  <= w_fcnt_nx;
         r_demo  <= (w_state_nx == S_DEMO);
         r_chg   <= (w_sel_nx != r_sel);
      end
   end

   // Frame update uses the current state; a mode pulse then overrides the state.
   always_comb begin
      w_state_nx = r_state;
      w_sel_nx   = r_sel;
      w_pend_nx  = r_pend;
      w_fcnt_nx  = r_fcnt;
      case (r_state)
         S_MANUAL: begin
            if (new_frame_in) w_sel_nx = r_sw_sync;
            if (w_mode_p) begin
               w_state_nx = S_STEP;
               w_pend_nx  = r_sel;
            end
         end
         S_STEP: begin
            if (new_frame_in) w_sel_nx = r_pend;
            if (w_mode_p) begin
               w_state_nx = S_DEMO;
               w_fcnt_nx  = '0;
            end else if (w_next_p) begin
               w_pend_nx = f_nxt(r_pend);
            end
         end
         S_DEMO: begin
            if (new_frame_in) begin
               if (r_fcnt == c_FC_LAST) begin
                  w_fcnt_nx = '0;
                  w_sel_nx  = f_nxt(r_sel);
               end else begin
                  w_fcnt_nx = r_fcnt + 1'b1;
               end
            end
            if (w_mode_p) w_state_nx = S_MANUAL;
         end
         default: w_state_nx = S_MANUAL;
      endcase
   end

   assign sel_out         = r_sel;
   assign demo_active_out = r_demo;
   assign sel_changed_out = r_chg;

endmodule
`default_nettype wire

// File: tb/tb_vga_mux_ctrl.sv
`default_nettype none
// ============================================================================
// tb_vga_mux_ctrl : directed vector table plus randomized run against a model
// Revision: 1.0
// ============================================================================
module tb_vga_mux_ctrl;
   localparam int DB = 4;
   localparam int DF = 3;
   localparam int M_MANUAL = 0;
   localparam int M_STEP   = 1;
   localparam int M_DEMO   = 2;

   logic       clk = 1'b0;
   logic       rst_in = 1'b1;
   logic [3:0] sw_sel_in = '0;
   logic       btn_next_in = 1'b0;
   logic       btn_mode_in = 1'b0;
   logic       new_frame_in = 1'b0;
   logic [3:0] sel_out;
   logic       demo_active_out;
   logic       sel_changed_out;

   vga_mux_ctrl #(.DEBOUNCE_CYCLES(DB), .DEMO_FRAMES(DF)) dut (
      .clk_in          (clk),
      .rst_in          (rst_in),
      .sw_sel_in       (sw_sel_in),
      .btn_next_in     (btn_next_in),
      .btn_mode_in     (btn_mode_in),
      .new_frame_in    (new_frame_in),
      .sel_out         (sel_out),
      .demo_active_out (demo_active_out),
      .sel_changed_out (sel_changed_out)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model: raw-input histories since reset plus spec-level state.
   logic [3:0] h_sw[$];
   logic       h_nb[$], h_mb[$], a_nb[$], a_mb[$];
   int         m_mode;
   logic [3:0] m_sel, m_pend;
   int         m_fcnt;
   logic       m_chg, m_demo;

   function automatic logic [3:0] nxt(input logic [3:0] x);
      logic [3:0] v;
      v = x + 4'd1;
`ifdef VGA_MUX_CTRL_SKIP_TEST_EN
      if (v[3:2] == 2'b11) v = 4'd0;
`endif
      return v;
   endfunction

   function automatic logic raw_at(input int b, input int i);
      if (i < 0) return 1'b0;
      return (b == 0) ? h_nb[i] : h_mb[i];
   endfunction

   function automatic logic acc_at(input int b, input int i);
      if (i < 0) return 1'b0;
      return (b == 0) ? a_nb[i] : a_mb[i];
   endfunction

   task automatic model_edge(input logic rst, input logic [3:0] sw,
                             input logic nb, input logic mb, input logic nf);
      int         e;
      logic [3:0] sync, old;
      logic       np, mp, prev, flip;
      if (rst) begin
         h_sw.delete(); h_nb.delete(); h_mb.delete(); a_nb.delete(); a_mb.delete();
         m_mode = M_MANUAL; m_sel = '0; m_pend = '0; m_fcnt = 0;
         m_chg = 1'b0; m_demo = 1'b0;
         return;
      end
      e    = h_sw.size();
      sync = (e >= 2) ? h_sw[e-2] : 4'd0;
      np   = acc_at(0, e-2) & ~acc_at(0, e-3);
      mp   = acc_at(1, e-2) & ~acc_at(1, e-3);
      h_sw.push_back(sw); h_nb.push_back(nb); h_mb.push_back(mb);
      for (int b = 0; b < 2; b++) begin
         prev = acc_at(b, e-1);
         flip = 1'b1;
         for (int k = 0; k < DB; k++)
            if (raw_at(b, e-2-k) == prev) flip = 1'b0;
         if (b == 0) a_nb.push_back(flip ? ~prev : prev);
         else        a_mb.push_back(flip ? ~prev : prev);
      end
      old = m_sel;
      if (m_mode == M_MANUAL) begin
         if (nf) m_sel = sync;
      end else if (m_mode == M_STEP) begin
         if (nf) m_sel = m_pend;
         if (np && !mp) m_pend = nxt(m_pend);
      end else begin
         if (nf) begin
            if (m_fcnt == DF-1) begin m_fcnt = 0; m_sel = nxt(m_sel); end
            else m_fcnt = m_fcnt + 1;
         end
      end
      if (mp) begin
         if (m_mode == M_MANUAL)    begin m_mode = M_STEP; m_pend = old; end
         else if (m_mode == M_STEP) begin m_mode = M_DEMO; m_fcnt = 0; end
         else                       m_mode = M_MANUAL;
      end
      m_chg  = (m_sel != old);
      m_demo = (m_mode == M_DEMO);
   endtask

   task automatic step(input logic rst, input logic [3:0] sw,
                       input logic nb, input logic mb, input logic nf);
      rst_in = rst; sw_sel_in = sw; btn_next_in = nb; btn_mode_in = mb; new_frame_in = nf;
      @(posedge clk);
      model_edge(rst, sw, nb, mb, nf);
      #1;
      n_cmp++;
      if ({sel_out, sel_changed_out, demo_active_out} !== {m_sel, m_chg, m_demo}) begin
         n_bad++;
         $display("FAIL model cyc=%0d: sel=%0d chg=%b demo=%b, expected sel=%0d chg=%b demo=%b",
                  cyc, sel_out, sel_changed_out, demo_active_out, m_sel, m_chg, m_demo);
      end
      cyc++;
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] sw;
      logic       nb, mb, nf;
      int         n;
      logic [3:0] sel;
      logic       chg, demo;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic [3:0] sw, input logic nb,
                               input logic mb, input logic nf, input int n,
                               input logic [3:0] sel, input logic chg, input logic demo);
      vec_t v;
      v.rst = rst; v.sw = sw; v.nb = nb; v.mb = mb; v.nf = nf; v.n = n;
      v.sel = sel; v.chg = chg; v.demo = demo;
      return v;
   endfunction

   vec_t tbl[30];

   initial begin
      logic [3:0] rsw;
      logic       rnb, rmb;
      int         hold_nb, hold_mb;
`ifdef VGA_MUX_CTRL_SKIP_TEST_EN
      logic [3:0] wrap_a = 4'd3, wrap_b = 4'd4, wrap_c = 4'd5;
`else
      logic [3:0] wrap_a = 4'd15, wrap_b = 4'd0, wrap_c = 4'd1;
`endif
      //            rst sw  nb mb nf  n   sel    chg demo
      tbl[0]  = mk(1, 0, 0, 0, 0,  2, 0,      0, 0);
      tbl[1]  = mk(0, 6, 0, 0, 0,  3, 0,      0, 0);
      tbl[2]  = mk(0, 6, 0, 0, 1,  1, 6,      1, 0);
      tbl[3]  = mk(0, 6, 0, 0, 0,  1, 6,      0, 0);
      tbl[4]  = mk(0, 6, 0, 1, 0, 10, 6,      0, 0);
      tbl[5]  = mk(0, 6, 0, 0, 0, 10, 6,      0, 0);
      tbl[6]  = mk(0, 6, 1, 0, 0,  2, 6,      0, 0);
      tbl[7]  = mk(0, 6, 0, 0, 0,  8, 6,      0, 0);
      tbl[8]  = mk(0, 6, 0, 0, 1,  1, 6,      0, 0);
      tbl[9]  = mk(0, 6, 1, 0, 0, 10, 6,      0, 0);
      tbl[10] = mk(0, 6, 0, 0, 0, 10, 6,      0, 0);
      tbl[11] = mk(0, 6, 1, 0, 0, 10, 6,      0, 0);
      tbl[12] = mk(0, 6, 0, 0, 0, 10, 6,      0, 0);
      tbl[13] = mk(0, 6, 0, 0, 1,  1, 8,      1, 0);
      tbl[14] = mk(0, 6, 0, 0, 1,  1, 8,      0, 0);
      tbl[15] = mk(0, 6, 1, 0, 0,  7, 8,      0, 0);
      tbl[16] = mk(0, 6, 1, 0, 1,  1, 8,      0, 0);
      tbl[17] = mk(0, 6, 1, 0, 0,  2, 8,      0, 0);
      tbl[18] = mk(0, 6, 0, 0, 0, 10, 8,      0, 0);
      tbl[19] = mk(0, 6, 0, 0, 1,  1, 9,      1, 0);
      tbl[20] = mk(0, 6, 0, 1, 0, 10, 9,      0, 1);
      tbl[21] = mk(0, 6, 0, 0, 0, 10, 9,      0, 1);
      tbl[22] = mk(0, 6, 0, 0, 1, 18, wrap_a, 1, 1);
      tbl[23] = mk(0, 6, 0, 0, 1,  2, wrap_a, 0, 1);
      tbl[24] = mk(0, 6, 0, 0, 1,  1, wrap_b, 1, 1);
      tbl[25] = mk(0, 6, 0, 0, 1,  3, wrap_c, 1, 1);
      tbl[26] = mk(0, 6, 0, 0, 1,  2, wrap_c, 0, 1);
      tbl[27] = mk(1, 6, 0, 0, 0,  1, 0,      0, 0);
      tbl[28] = mk(0, 6, 0, 0, 0,  2, 0,      0, 0);
      tbl[29] = mk(0, 6, 0, 0, 1,  1, 6,      1, 0);

      for (int i = 0; i < 30; i++) begin
         for (int j = 0; j < tbl[i].n; j++)
            step(tbl[i].rst, tbl[i].sw, tbl[i].nb, tbl[i].mb, tbl[i].nf);
         n_cmp++;
         if ({sel_out, sel_changed_out, demo_active_out} !==
             {tbl[i].sel, tbl[i].chg, tbl[i].demo}) begin
            n_bad++;
            $display("FAIL vec%0d: sel=%0d chg=%b demo=%b, expected sel=%0d chg=%b demo=%b",
                     i, sel_out, sel_changed_out, demo_active_out,
                     tbl[i].sel, tbl[i].chg, tbl[i].demo);
         end
      end

      rsw = '0; rnb = 1'b0; rmb = 1'b0; hold_nb = 0; hold_mb = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hold_nb == 0) begin
            rnb = 1'($urandom_range(0, 1));
            hold_nb = $urandom_range(1, 14);
         end else hold_nb--;
         if (hold_mb == 0) begin
            rmb = 1'($urandom_range(0, 1));
            hold_mb = $urandom_range(1, 24);
         end else hold_mb--;
         if ($urandom_range(0, 9) == 0) rsw = 4'($urandom);
         step(($urandom_range(0, 799) == 0), rsw, rnb, rmb, ($urandom_range(0, 5) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
